// File: rtl/banked_ram_ctrl_if.sv
// Bus bundle for banked_ram_ctrl: init/busy control, read port, write port.
interface banked_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic              init;
  logic              busy;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rvalid;
  logic              parity_err;

  modport master (
    output init, ren, raddr, wen, waddr, din,
    input  busy, dout, rvalid, parity_err
  );

  modport slave (
    input  init, ren, raddr, wen, waddr, din,
    output busy, dout, rvalid, parity_err
  );
endinterface

// File: rtl/banked_ram_ctrl.sv
// Parametrised multi-bank RAM: one write port, one registered read port,
// hardware zero-fill sequencer, write-first bypass, block or interleaved
// bank mapping. Optional stored even parity enabled by BANKED_RAM_PARITY_EN.
module banked_ram_ctrl #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 2048,
  parameter int NUM_BANKS       = 4,
  parameter int BANK_INTERLEAVE = 0,
  parameter int ADDR_W          = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst_n,
  banked_ram_ctrl_if.slave bus
);
  localparam int WPB    = DEPTH / NUM_BANKS;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int IDX_W  = ADDR_W - BANK_W;
`ifdef BANKED_RAM_PARITY_EN
  localparam int MEM_W  = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
`endif

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic               busy_int;
  logic               acc_rd, acc_wr;
  logic [BANK_W-1:0]  wr_bank, rd_bank, sel_q;
  logic [IDX_W-1:0]   wr_idx, rd_idx, we_idx;
  logic [MEM_W-1:0]   wr_word, we_word, dout_word;
  logic [NUM_BANKS-1:0] bank_we;
  logic [MEM_W-1:0]   rd_word [NUM_BANKS];
  logic               rvalid_q;

  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    if (BANK_INTERLEAVE != 0) return a[BANK_W-1:0];
    else                      return a[ADDR_W-1 -: BANK_W];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    if (BANK_INTERLEAVE != 0) return a[ADDR_W-1:BANK_W];
    else                      return a[IDX_W-1:0];
  endfunction

  assign wr_bank = bank_of(bus.waddr);
  assign wr_idx  = idx_of(bus.waddr);
  assign rd_bank = bank_of(bus.raddr);
  assign rd_idx  = idx_of(bus.raddr);
  assign acc_rd  = !busy_int && bus.ren;
  assign acc_wr  = !busy_int && bus.wen;

  // Stored word for an external write (data plus even parity when enabled)
  always_comb begin
`ifdef BANKED_RAM_PARITY_EN
    wr_word = {^bus.din, bus.din};
`else
    wr_word = bus.din;
`endif
  end

  // Write steering: zero-fill hits every bank at cnt, otherwise one bank
  always_comb begin
    bank_we = '0;
    we_idx  = wr_idx;
    we_word = wr_word;
    if (busy_int) begin
      bank_we = '1;
      we_idx  = cnt;
      we_word = '0;
    end else if (bus.wen) begin
      bank_we[wr_bank] = 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [MEM_W-1:0] mem [WPB];
    logic [MEM_W-1:0] rd_q;

    // Bank array write
    always_ff @(posedge clk) begin
      if (bank_we[b]) mem[we_idx] <= we_word;
    end

    // Registered bank read; a same-address write in the same cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else if (acc_rd && rd_bank == BANK_W'(b)) begin
        rd_q <= (acc_wr && bus.waddr == bus.raddr) ? wr_word : mem[rd_idx];
      end
    end

    assign rd_word[b] = rd_q;
  end

  // Output mux select and read-valid travel with the read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      rvalid_q <= acc_rd;
      if (acc_rd) sel_q <= rd_bank;
    end
  end

  assign dout_word   = rd_word[sel_q];
  assign bus.dout    = dout_word[DATA_W-1:0];
  assign bus.rvalid  = rvalid_q;
`ifdef BANKED_RAM_PARITY_EN
  assign bus.parity_err = rvalid_q && ((^dout_word[DATA_W-1:0]) != dout_word[DATA_W]);
`else
  assign bus.parity_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Zero-fill index; wraps to 0 on the last INIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (state == S_INIT)  cnt <= cnt + 1'b1;
    else if (bus.init)         cnt <= '0;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (cnt == '1) state_nxt = S_IDLE;
      S_IDLE:  if (bus.init)  state_nxt = S_INIT;
      default: state_nxt = S_INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_int = (state == S_INIT);
  end

  assign bus.busy = busy_int;
endmodule
